csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
- Parametrised machine-mode CSR file for the single-hart core; next generation of the current minimal CSR block.
- Adds trap entry/return sequencing, mstatus/mcause/mtval/mscratch/mip, vectored mtvec, read-only and illegal-access detection, and 64-bit cycle/instret counters.
- Sits beside the decode/execute stage. Reads are combinational. Writes and trap/mret updates commit on the rising clk edge.

Parameters:
- XLEN, 32, CSR data width; only 32 is supported.
- CNT_WIDTH, 64, width of mcycle/minstret; 33..64.
- HART_ID, 0, value returned by mhartid.
- MTVEC_RESET, 32'h0, reset value of mtvec (BASE and MODE).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- number  in  12  CSR address.
- access_type  in  2  READ_ONLY/WRITE/SET/CLEAR, using the existing CSR access encodings.
- in  in  XLEN  write/set/clear operand.
- out  out  XLEN  current value of the addressed CSR (combinational).
- illegal  out  1  unknown CSR, or a write to a read-only CSR (combinational).
- retire  in  1  one instruction retired this cycle.
- trap  in  1  take a trap this cycle.
- trap_cause  in  XLEN  mcause value; bit XLEN-1 set means interrupt.
- trap_pc  in  XLEN  PC to save in mepc.
- trap_value  in  XLEN  value to save in mtval.
- mret  in  1  execute mret this cycle.
- mtip, msip, meip  in  1 each  interrupt lines.
- trap_vector  out  XLEN  target PC for a trap (combinational).
- epc  out  XLEN  current mepc.
- irq_pending  out  1  equals mstatus.MIE & |(mie & mip).

Behaviour:
- Reset (reset=0, asynchronous):
  - mstatus MIE=0, MPIE=0, MPP=2'b11.
  - mie=0, mepc=0, mcause=0, mtval=0, mscratch=0.
  - mtvec=MTVEC_RESET, mcycle=0, minstret=0.
- Outputs follow from the reset state: out depends only on number; illegal is 0 for known CSRs.
- Write qualification: a write occurs when access_type!=READ_ONLY. Exception: SET/CLEAR with in==0 is a pure read, so no write and no illegal.
- next value: WRITE uses in; SET uses current|in; CLEAR uses current&~in.
- Read-only CSRs are those with number[11:10]==2'b11.
  - A qualified write to one sets illegal=1 and changes no state.
  - The same applies to unknown addresses; an unknown address also reads 0.
- Implemented CSRs:
  - misa = 0x40000100.
  - mvendorid, marchid, mimpid = 0; mhartid = HART_ID.
  - mstatus: only MIE[3], MPIE[7] and MPP[12:11] are held; MPP is hardwired 2'b11 and all other bits read 0.
  - mie: MEIE[11], MTIE[7], MSIE[3]; other bits read 0.
  - mip: {meip,mtip,msip} in the same positions; read-only, writes are ignored without flagging illegal.
  - mtvec: MODE[1:0] accepts 0 or 1; a written value of 2 or 3 stores MODE=0.
  - mepc: bits [1:0] are forced to 0.
  - mcause, mtval, mscratch: full XLEN.
  - Counter CSRs are described under Optional Feature.
- trap_vector:
  - MODE=0, or a synchronous cause: mtvec.BASE.
  - MODE=1 and interrupt cause: BASE + 4*cause[XLEN-2:0], modulo 2^XLEN.
- Trap entry (trap=1), in one cycle:
  - mepc <= trap_pc with [1:0]=0; mcause <= trap_cause; mtval <= trap_value.
  - MPIE <= MIE; MIE <= 0.
- mret=1: MIE <= MPIE; MPIE <= 1.
- Same-cycle priority: trap > mret > CSR write. A lower-priority update that conflicts is dropped whole, e.g. a CSR write in a trap cycle is discarded entirely.
- illegal is combinational and does not depend on trap or mret.
- irq_pending is combinational from the current state and the interrupt lines.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined:
  - mcycle increments every cycle after reset; minstret increments when retire=1. Both wrap modulo 2^CNT_WIDTH.
  - Address map: mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82; read-only shadows cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82.
  - High halves read bits [CNT_WIDTH-1:32], zero-extended.
  - Writing either half replaces that half. That counter does not increment in that cycle; the other counter still counts.
- Undefined: all these addresses are unknown CSRs (read 0; qualified writes flag illegal). No counter flops exist.

Decomposition:
- Package csr_pkg holds:
  - access_type enum;
  - CSR address constants;
  - mstatus/mie/mip bit-index constants;
  - mcause interrupt-bit constant;
  - the mtvec_mode_t typedef.
- One sub-module, csr_counter: CNT_WIDTH counter with inc, wr_lo, wr_hi, wdata and value; instantiated twice when CSR_COUNTERS_EN is defined.

Test Plan:
- Reset mid-operation:
  - Stimulus: write mscratch=0xDEADBEEF, then pulse reset=0 asynchronously (no clock edge).
  - Response: mscratch reads 0 immediately; mtvec reads MTVEC_RESET; mstatus reads 0x1800.
- Set/clear:
  - Stimulus: write mie=0x888, then CLEAR with in=0x080.
  - Response: mie reads 0x808.
  - Then SET mhartid with in=0: illegal=0. Then WRITE mhartid=5: illegal=1, read still HART_ID.
- Trap then mret:
  - Stimulus: MIE=1; trap with cause 0x80000007, trap_pc 0x103, mtvec 0x101.
  - Response: trap_vector=0x11C; next cycle mepc=0x100, MIE=0, MPIE=1.
  - Then mret: MIE=1, MPIE=1.
- Simultaneous events:
  - Stimulus: trap=1 and a WRITE to mepc=0x40 in the same cycle.
  - Response: mepc holds trap_pc, the 0x40 write is dropped.
  - Stimulus: mret together with a write to mstatus.
  - Response: mret result wins.
- Interrupt pending:
  - Stimulus: mie.MTIE=1, mtip=1, MIE=0.
  - Response: irq_pending=0; after setting MIE=1, irq_pending=1 in the same cycle.
- Counters (CSR_COUNTERS_EN):
  - Stimulus: write mcycle=0xFFFFFFFF and mcycleh=0, then run 2 cycles.
  - Response: reads mcycle=0x00000001, mcycleh=0x00000001.
  - Stimulus: retire held high for 3 cycles.
  - Response: minstret +3.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared types and constants for the machine-mode CSR file.
// Holds the access-type encoding, CSR addresses, bit positions inside
// mstatus/mie/mip/mcause and the mtvec mode type.
package csr_pkg;

  // CSR instruction access encodings used by decode
  typedef enum logic [1:0] {
    ACC_READ_ONLY = 2'd0,
    ACC_WRITE     = 2'd1,
    ACC_SET       = 2'd2,
    ACC_CLEAR     = 2'd3
  } access_type_e;

  // mtvec MODE field; only direct and vectored are legal
  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1
  } mtvec_mode_t;

  // Machine information registers
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Machine trap setup and handling
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;

  // Counters and their read-only user shadows
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // mstatus fields
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

  // mie / mip fields share positions
  localparam int IRQ_MSI_BIT = 3;
  localparam int IRQ_MTI_BIT = 7;
  localparam int IRQ_MEI_BIT = 11;
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  // mcause interrupt flag
  localparam int MCAUSE_INT_BIT = 31;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

endpackage

// File: rtl/csr_counter.sv
// csr_counter: CNT_WIDTH-bit free-running counter whose low and high
// 32-bit halves can be overwritten. A write in a cycle suppresses that
// cycle's increment so software sees exactly the value it wrote.
module csr_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] value
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Next count: half-replacement on write, otherwise wrap-around increment
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) cnt_d[31:0] = wdata;
      if (wr_hi) cnt_d[CNT_WIDTH-1:32] = wdata[CNT_WIDTH-33:0];
    end else if (inc) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter register, cleared by the active-low async reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the single-hart core.
// Combinational reads, clocked writes, trap entry and mret sequencing.
// Same-cycle priority is trap > mret > CSR write; a CSR write in a trap
// or mret cycle is dropped entirely.
// Optional macro CSR_COUNTERS_EN adds mcycle/minstret and their shadows;
// without it those addresses are unknown CSRs.
module csr_file
  import csr_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter int               CNT_WIDTH   = 64,
  parameter logic [XLEN-1:0]  HART_ID     = '0,
  parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     number,
  input  logic [1:0]      access_type,
  input  logic [XLEN-1:0] in,
  output logic [XLEN-1:0] out,
  output logic            illegal,
  input  logic            retire,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_value,
  input  logic            mret,
  input  logic            mtip,
  input  logic            msip,
  input  logic            meip,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] epc,
  output logic            irq_pending
);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;

  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] mip_val;
  logic [XLEN-1:0] tvec_base;
  logic            known;
  logic            read_only;
  logic            wr_req;
  logic            wr_en;
  mtvec_mode_t     wr_mode;

  assign mip_val = {{(XLEN-12){1'b0}}, meip, 3'b000, mtip, 3'b000, msip, 3'b000};

  // SET/CLEAR with a zero operand is a pure read and never writes
  assign wr_req    = (access_type != ACC_READ_ONLY) &&
                     !(((access_type == ACC_SET) || (access_type == ACC_CLEAR)) && (in == '0));
  assign read_only = (number[11:10] == 2'b11);
  assign illegal   = wr_req && (!known || read_only);
  assign wr_en     = wr_req && !illegal && !trap && !mret;
  assign wr_mode   = wdata[1] ? MTVEC_DIRECT : mtvec_mode_t'(wdata[1:0]);

`ifdef CSR_COUNTERS_EN
  logic [CNT_WIDTH-1:0] mcycle_value;
  logic [CNT_WIDTH-1:0] minstret_value;

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (wr_en && (number == CSR_MCYCLE)),
    .wr_hi (wr_en && (number == CSR_MCYCLEH)),
    .wdata (wdata),
    .value (mcycle_value)
  );

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .wr_lo (wr_en && (number == CSR_MINSTRET)),
    .wr_hi (wr_en && (number == CSR_MINSTRETH)),
    .wdata (wdata),
    .value (minstret_value)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  // Read mux: value of the addressed CSR and whether the address exists
  always_comb begin
    rdata = '0;
    known = 1'b1;
    case (number)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        rdata[MSTATUS_MPIE_BIT]              = mstatus_mpie_q;
        rdata[MSTATUS_MIE_BIT]               = mstatus_mie_q;
      end
      CSR_MISA:      rdata = MISA_VALUE;
      CSR_MIE:       rdata = mie_q;
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MTVAL:     rdata = mtval_q;
      CSR_MIP:       rdata = mip_val;
      CSR_MVENDORID: rdata = '0;
      CSR_MARCHID:   rdata = '0;
      CSR_MIMPID:    rdata = '0;
      CSR_MHARTID:   rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,   CSR_CYCLE:    rdata = mcycle_value[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   rdata = XLEN'(mcycle_value[CNT_WIDTH-1:32]);
      CSR_MINSTRET, CSR_INSTRET:  rdata = minstret_value[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata = XLEN'(minstret_value[CNT_WIDTH-1:32]);
`endif
      default:       known = 1'b0;
    endcase
  end

  assign out = rdata;

  // Write data for WRITE / SET / CLEAR based on the current value
  always_comb begin
    wdata = in;
    case (access_type)
      ACC_SET:   wdata = rdata | in;
      ACC_CLEAR: wdata = rdata & ~in;
      default:   wdata = in;
    endcase
  end

  // Next state: trap entry, then mret, then a qualified CSR write
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mscratch_d     = mscratch_q;
    if (trap) begin
      mepc_d         = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d       = trap_cause;
      mtval_d        = trap_value;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (number)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wdata[MSTATUS_MIE_BIT];
          mstatus_mpie_d = wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d      = wdata & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = {wdata[XLEN-1:2], wr_mode};
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = {wdata[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wdata;
        CSR_MTVAL:    mtval_d    = wdata;
        default:      ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mscratch_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mscratch_q     <= mscratch_d;
    end
  end

  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  // Trap target: vectored mode offsets interrupts by 4*cause
  always_comb begin
    trap_vector = tvec_base;
    if ((mtvec_mode_t'(mtvec_q[1:0]) == MTVEC_VECTORED) && trap_cause[MCAUSE_INT_BIT])
      trap_vector = tvec_base + {trap_cause[XLEN-3:0], 2'b00};
  end

  assign epc         = mepc_q;
  assign irq_pending = mstatus_mie_q && |(mie_q & mip_val);

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: self-checking bench for csr_file.
// Table of post-reset read/illegal vectors, hand-written multi-cycle
// sequences, then randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_csr_file;
  import csr_pkg::*;

  localparam logic [31:0] HART      = 32'd3;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0041;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] number = '0;
  logic [1:0]  access_type = '0;
  logic [31:0] din = '0;
  logic [31:0] out;
  logic        illegal;
  logic        retire = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_value = '0;
  logic        mret = 1'b0;
  logic        mtip = 1'b0, msip = 1'b0, meip = 1'b0;
  logic [31:0] trap_vector;
  logic [31:0] epc;
  logic        irq_pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_mie_b, m_mpie;
  logic [31:0] m_mie_r, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
  logic [63:0] m_cycle, m_instret;

  csr_file #(
    .XLEN(32), .CNT_WIDTH(64), .HART_ID(HART), .MTVEC_RESET(MTVEC_RST)
  ) dut (
    .clk(clk), .reset(reset), .number(number), .access_type(access_type),
    .in(din), .out(out), .illegal(illegal), .retire(retire), .trap(trap),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_value(trap_value),
    .mret(mret), .mtip(mtip), .msip(msip), .meip(meip),
    .trap_vector(trap_vector), .epc(epc), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_mip();
    return (32'(meip) << 11) | (32'(mtip) << 7) | (32'(msip) << 3);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie_b) << 3);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie_r;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip();
      12'hF14: return HART;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_known(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
      12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB02, 12'hB80, 12'hB82,
      12'hC00, 12'hC02, 12'hC80, 12'hC82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_wr_req(input logic [1:0] acc, input logic [31:0] d);
    return (acc != 2'd0) && !((acc >= 2'd2) && (d == 32'h0));
  endfunction

  function automatic bit m_illegal(input logic [11:0] a, input logic [1:0] acc, input logic [31:0] d);
    return m_wr_req(acc, d) && (!m_known(a) || (a >= 12'hC00));
  endfunction

  function automatic logic [31:0] m_tvec(input logic [31:0] cause);
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if ((m_mtvec % 4 == 1) && cause[31]) return base + (cause & 32'h7FFF_FFFF) * 4;
    return base;
  endfunction

  function automatic bit m_irq();
    return m_mie_b && ((m_mie_r & m_mip()) != 0);
  endfunction

  task automatic model_reset();
    m_mie_b = 0; m_mpie = 0; m_mie_r = 0; m_mtvec = MTVEC_RST;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
    m_cycle = 0; m_instret = 0;
  endtask

  task automatic model_step();
    logic [31:0] nv;
    bit cyc_wr, ins_wr;
    cyc_wr = 0; ins_wr = 0;
    if (trap) begin
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_value;
      m_mpie = m_mie_b; m_mie_b = 0;
    end else if (mret) begin
      m_mie_b = m_mpie; m_mpie = 1;
    end else if (m_wr_req(access_type, din) && !m_illegal(number, access_type, din)) begin
      if (access_type == 2'd1)      nv = din;
      else if (access_type == 2'd2) nv = m_read(number) | din;
      else                          nv = m_read(number) & ~din;
      case (number)
        12'h300: begin m_mie_b = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie_r = nv & 32'h888;
        12'h305: m_mtvec = (nv % 4 >= 2) ? (nv & ~32'h3) : nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
`ifdef CSR_COUNTERS_EN
        12'hB00: begin m_cycle[31:0]    = nv; cyc_wr = 1; end
        12'hB80: begin m_cycle[63:32]   = nv; cyc_wr = 1; end
        12'hB02: begin m_instret[31:0]  = nv; ins_wr = 1; end
        12'hB82: begin m_instret[63:32] = nv; ins_wr = 1; end
`endif
        default: ;
      endcase
    end
    if (!cyc_wr) m_cycle = m_cycle + 1;
    if (!ins_wr && retire) m_instret = m_instret + 1;
  endtask

  // Reference model follows the DUT's clock and asynchronous reset
  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a CSR access on the falling edge; one-cycle controls are cleared
  task automatic applyStimulus(input logic [11:0] a, input logic [1:0] acc, input logic [31:0] d);
    @(negedge clk);
    number = a; access_type = acc; din = d;
    trap = 0; mret = 0; retire = 0;
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".out"}, out, m_read(number));
    checkValue({tag, ".illegal"}, 32'(illegal), 32'(m_illegal(number, access_type, din)));
    checkValue({tag, ".trap_vector"}, trap_vector, m_tvec(trap_cause));
    checkValue({tag, ".epc"}, epc, m_mepc);
    checkValue({tag, ".irq_pending"}, 32'(irq_pending), 32'(m_irq()));
  endtask

  typedef struct {
    logic [11:0] num;
    logic [1:0]  acc;
    logic [31:0] d;
    logic [31:0] exp_out;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[14];
  logic [11:0] addr_list[24];

  initial begin
    model_reset();
    vecs[0]  = '{12'h300, 2'd0, 32'h0,   32'h0000_1800, 1'b0};
    vecs[1]  = '{12'h301, 2'd0, 32'h0,   32'h4000_0100, 1'b0};
    vecs[2]  = '{12'hF14, 2'd0, 32'h0,   HART,          1'b0};
    vecs[3]  = '{12'hF14, 2'd1, 32'h5,   HART,          1'b1};
    vecs[4]  = '{12'hF14, 2'd2, 32'h0,   HART,          1'b0};
    vecs[5]  = '{12'hF11, 2'd3, 32'h1,   32'h0,         1'b1};
    vecs[6]  = '{12'h305, 2'd0, 32'h0,   MTVEC_RST,     1'b0};
    vecs[7]  = '{12'h344, 2'd1, 32'hFFF, 32'h0,         1'b0};
    vecs[8]  = '{12'h7C0, 2'd0, 32'h0,   32'h0,         1'b0};
    vecs[9]  = '{12'h7C0, 2'd1, 32'h1,   32'h0,         1'b1};
    vecs[10] = '{12'hC00, 2'd1, 32'h1,   32'h0,         1'b1};
    vecs[11] = '{12'hB00, 2'd0, 32'h0,   32'h0,         1'b0};
    vecs[12] = '{12'h304, 2'd2, 32'h0,   32'h0,         1'b0};
    vecs[13] = '{12'h7C0, 2'd3, 32'h0,   32'h0,         1'b0};

    // Reset held low: reads must show reset values, illegal per address
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].num, vecs[i].acc, vecs[i].d);
      #1;
      checkValue($sformatf("vec%0d.out", i), out, vecs[i].exp_out);
      checkValue($sformatf("vec%0d.illegal", i), 32'(illegal), 32'(vecs[i].exp_ill));
    end
    @(negedge clk); #2 reset = 1'b1;

    // Set / clear on mie, pure-read and write on mhartid
    applyStimulus(12'h304, 2'd1, 32'h888);
    applyStimulus(12'h304, 2'd3, 32'h080);
    applyStimulus(12'h304, 2'd0, 32'h0); #1;
    checkValue("mie_clear", out, 32'h808);
    applyStimulus(12'hF14, 2'd2, 32'h0); #1;
    checkValue("mhartid_set0_illegal", 32'(illegal), 32'h0);
    applyStimulus(12'hF14, 2'd1, 32'h5); #1;
    checkValue("mhartid_wr_illegal", 32'(illegal), 32'h1);
    checkValue("mhartid_wr_value", out, HART);

    // mtvec mode 3 collapses to direct, mepc low bits are forced to 0
    applyStimulus(12'h305, 2'd1, 32'h203);
    applyStimulus(12'h341, 2'd1, 32'h123);
    applyStimulus(12'h305, 2'd0, 32'h0); #1;
    checkValue("mtvec_mode3", out, 32'h200);
    checkValue("mepc_align", epc, 32'h120);

    // Asynchronous reset in the middle of a cycle
    applyStimulus(12'h340, 2'd1, 32'hDEAD_BEEF);
    applyStimulus(12'h340, 2'd0, 32'h0); #1;
    checkValue("mscratch_pre_reset", out, 32'hDEAD_BEEF);
    #0.5 reset = 1'b0;
    #0.5 checkValue("mscratch_async_reset", out, 32'h0);
    number = 12'h305;
    #0.5 checkValue("mtvec_async_reset", out, MTVEC_RST);
    number = 12'h300;
    #0.5 checkValue("mstatus_async_reset", out, 32'h1800);
    #0.5 reset = 1'b1;

    // Trap entry with vectored interrupt, then mret
    applyStimulus(12'h300, 2'd1, 32'h8);
    applyStimulus(12'h305, 2'd1, 32'h101);
    applyStimulus(12'h340, 2'd0, 32'h0);
    trap = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h103; trap_value = 32'h55;
    #1 checkValue("trap_vector_irq", trap_vector, 32'h11C);
    applyStimulus(12'h300, 2'd0, 32'h0); #1;
    checkValue("trap_mepc", epc, 32'h100);
    checkValue("trap_mstatus", out, 32'h1880);
    trap_cause = 32'h2;
    #1 checkValue("trap_vector_sync", trap_vector, 32'h100);
    applyStimulus(12'h342, 2'd0, 32'h0); #1;
    checkValue("trap_mcause", out, 32'h8000_0007);
    mret = 1;
    applyStimulus(12'h300, 2'd0, 32'h0); #1;
    checkValue("mret_mstatus", out, 32'h1888);

    // Trap beats a same-cycle write; mret beats an mstatus write
    applyStimulus(12'h341, 2'd1, 32'h40);
    trap = 1; trap_cause = 32'h2; trap_pc = 32'h204; trap_value = 32'h0;
    applyStimulus(12'h341, 2'd0, 32'h0); #1;
    checkValue("trap_vs_write", out, 32'h204);
    applyStimulus(12'h300, 2'd1, 32'h0);
    mret = 1;
    applyStimulus(12'h300, 2'd0, 32'h0); #1;
    checkValue("mret_vs_write", out, 32'h1888);

    // Pending interrupt gated by mstatus.MIE
    applyStimulus(12'h304, 2'd1, 32'h080);
    mtip = 1;
    applyStimulus(12'h300, 2'd1, 32'h0);
    applyStimulus(12'h300, 2'd2, 32'h8); #1;
    checkValue("irq_gated", 32'(irq_pending), 32'h0);
    applyStimulus(12'h300, 2'd0, 32'h0); #1;
    checkValue("irq_enabled", 32'(irq_pending), 32'h1);
    mtip = 0;

`ifdef CSR_COUNTERS_EN
    // Counter half writes and carry across the 32-bit boundary
    applyStimulus(12'hB00, 2'd1, 32'hFFFF_FFFF);
    applyStimulus(12'hB80, 2'd1, 32'h0);
    applyStimulus(12'hB00, 2'd0, 32'h0);
    applyStimulus(12'hB00, 2'd0, 32'h0);
    applyStimulus(12'hB00, 2'd0, 32'h0); #1;
    checkValue("mcycle_lo", out, 32'h1);
    number = 12'hB80;
    #1 checkValue("mcycle_hi", out, 32'h1);
    number = 12'hC80;
    #1 checkValue("cycleh_shadow", out, 32'h1);
    applyStimulus(12'hB02, 2'd1, 32'd10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(12'hB02, 2'd0, 32'h0);
      retire = 1;
    end
    applyStimulus(12'hB02, 2'd0, 32'h0); #1;
    checkValue("minstret_plus3", out, 32'd13);
`endif

    // Randomized traffic against the model
    addr_list = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                  12'h342, 12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF14,
                  12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02,
                  12'hC80, 12'hC82, 12'h7C0, 12'h123, 12'h305, 12'h300};
    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      applyStimulus(addr_list[$urandom_range(0, 23)], 2'($urandom_range(0, 3)), d);
      trap       = ($urandom_range(0, 15) == 0);
      mret       = ($urandom_range(0, 15) == 0);
      retire     = 1'($urandom_range(0, 1));
      trap_cause = {1'($urandom_range(0, 1)), 27'h0, 4'($urandom)};
      trap_pc    = $urandom;
      trap_value = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        mtip = 1'($urandom); msip = 1'($urandom); meip = 1'($urandom);
      end
      #1 checkOutput($sformatf("rnd%0d", i));
    end

    applyStimulus(12'h300, 2'd0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
